serpent_decrypt_ctrl: RTL and testbench

SERPENT_DECRYPT_CTRL -- requirements
Module: serpent_decrypt_ctrl

---
 rtl/serpent_decrypt_ctrl.sv | 143 ++++++++++++++
 tb/tb_serpent_decrypt_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_decrypt_ctrl.sv
// ============================================================================
// Module  : serpent_decrypt_ctrl
// Brief   : Iterative Serpent block decryption, one round per clock, with
//           externally supplied round keys and valid/ready handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serpent_decrypt_ctrl (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_block,
    output logic [5:0]   o_key_idx,
    input  logic [127:0] i_round_key,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_block,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WHITEN = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_INV_SBOX [8][16] = '{
        '{4'd13, 4'd3,  4'd11, 4'd0,  4'd10, 4'd6,  4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd15, 4'd9,  4'd8,  4'd2},
        '{4'd5,  4'd8,  4'd2,  4'd14, 4'd15, 4'd6,  4'd12, 4'd3,  4'd11, 4'd4,  4'd7,  4'd9,  4'd1,  4'd13, 4'd10, 4'd0},
        '{4'd12, 4'd9,  4'd15, 4'd4,  4'd11, 4'd14, 4'd1,  4'd2,  4'd0,  4'd3,  4'd6,  4'd13, 4'd5,  4'd8,  4'd10, 4'd7},
        '{4'd0,  4'd9,  4'd10, 4'd7,  4'd11, 4'd14, 4'd6,  4'd13, 4'd3,  4'd5,  4'd12, 4'd2,  4'd4,  4'd8,  4'd15, 4'd1},
        '{4'd5,  4'd0,  4'd8,  4'd3,  4'd10, 4'd9,  4'd7,  4'd14, 4'd2,  4'd12, 4'd11, 4'd6,  4'd4,  4'd15, 4'd13, 4'd1},
        '{4'd8,  4'd15, 4'd2,  4'd9,  4'd4,  4'd1,  4'd13, 4'd14, 4'd11, 4'd6,  4'd5,  4'd3,  4'd7,  4'd12, 4'd10, 4'd0},
        '{4'd15, 4'd10, 4'd1,  4'd13, 4'd5,  4'd3,  4'd6,  4'd0,  4'd4,  4'd9,  4'd14, 4'd7,  4'd2,  4'd12, 4'd8,  4'd11},
        '{4'd3,  4'd0,  4'd6,  4'd13, 4'd9,  4'd14, 4'd15, 4'd8,  4'd5,  4'd12, 4'd11, 4'd7,  4'd10, 4'd1,  4'd4,  4'd2}
    };

    // Bitsliced: bit j of each word forms one nibble, w0 supplying the LSB.
    function automatic logic [127:0] inv_sbox(input logic [2:0] k, input logic [127:0] x);
        logic [3:0]   nib;
        logic [3:0]   s;
        logic [127:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            nib       = {x[96+j], x[64+j], x[32+j], x[j]};
            s         = c_INV_SBOX[k][nib];
            y[j]      = s[0];
            y[32+j]   = s[1];
            y[64+j]   = s[2];
            y[96+j]   = s[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_lt(input logic [127:0] x);
        logic [31:0] w0, w1, w2, w3;
        {w3, w2, w1, w0} = x;
        w2 = {w2[21:0], w2[31:22]};
        w0 = {w0[4:0],  w0[31:5]};
        w2 = w2 ^ w3 ^ (w1 << 7);
        w0 = w0 ^ w1 ^ w3;
        w3 = {w3[6:0],  w3[31:7]};
        w1 = {w1[0],    w1[31:1]};
        w3 = w3 ^ w2 ^ (w0 << 3);
        w1 = w1 ^ w0 ^ w2;
        w2 = {w2[2:0],  w2[31:3]};
        w0 = {w0[12:0], w0[31:13]};
        return {w3, w2, w1, w0};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] x_q, x_d;
    logic [4:0]   r_q, r_d;
    logic [127:0] round_out;

    // The first inverse round (r=31) has no linear transform in front of it.
    always_comb begin
        round_out = inv_sbox(r_q[2:0], (r_q == 5'd31) ? x_q : inv_lt(x_q)) ^ i_round_key;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        r_d       = r_q;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        o_key_idx = 6'd32;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    x_d     = i_block;
                    state_d = WHITEN;
                end
            end
            WHITEN: begin
                o_busy  = 1'b1;
                x_d     = x_q ^ i_round_key;
                r_d     = 5'd31;
                state_d = ROUND;
            end
            ROUND: begin
                o_busy    = 1'b1;
                o_key_idx = {1'b0, r_q};
                x_d       = round_out;
                if (r_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q - 5'd1;
                end
            end
            DONE: begin
                o_valid   = 1'b1;
                o_key_idx = 6'd0;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_block = (state_q == DONE) ? x_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_serpent_decrypt_ctrl.sv
// ============================================================================
// Module  : tb_serpent_decrypt_ctrl
// Brief   : Directed and random bench for serpent_decrypt_ctrl, with a
//           forward Serpent encrypt model producing the ciphertexts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serpent_decrypt_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_block;
    logic [5:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         in_ready;
    logic [127:0] out_block;
    logic         busy;

    logic [127:0] key_mem [0:32];

    always #5 clk = ~clk;

    assign round_key = (key_idx <= 6'd32) ? key_mem[key_idx] : '0;

    serpent_decrypt_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_block     (in_block),
        .o_key_idx   (key_idx),
        .i_round_key (round_key),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_block     (out_block),
        .o_busy      (busy)
    );

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] sbox_fwd(input int k, input logic [127:0] x);
        logic [3:0]   nib;
        logic [3:0]   s;
        logic [127:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            nib = {x[96+j], x[64+j], x[32+j], x[j]};
            s   = SBOX[k][nib];
            {y[96+j], y[64+j], y[32+j], y[j]} = s;
        end
        return y;
    endfunction

    function automatic logic [127:0] lt_fwd(input logic [127:0] x);
        logic [31:0] w0, w1, w2, w3;
        {w3, w2, w1, w0} = x;
        w0 = rol(w0, 13);
        w2 = rol(w2, 3);
        w1 = w1 ^ w0 ^ w2;
        w3 = w3 ^ w2 ^ (w0 << 3);
        w1 = rol(w1, 1);
        w3 = rol(w3, 7);
        w0 = w0 ^ w1 ^ w3;
        w2 = w2 ^ w3 ^ (w1 << 7);
        w0 = rol(w0, 5);
        w2 = rol(w2, 22);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] x;
        x = pt;
        for (int i = 0; i < 32; i++) begin
            x = sbox_fwd(i % 8, x ^ key_mem[i]);
            if (i < 31) x = lt_fwd(x);
            else        x = x ^ key_mem[32];
        end
        return x;
    endfunction

    // Seed 0 gives an all-zero key schedule.
    task automatic fill_keys(input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i <= 32; i++) begin
            for (int w = 0; w < 4; w++) begin
                s = s * 32'd1664525 + 32'd1013904223;
                key_mem[i][w*32 +: 32] = (seed == 32'd0) ? 32'd0 : s;
            end
        end
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_block(input logic [127:0] ct, input int gap, input bit noisy,
                             input bit glitch, output logic [127:0] res,
                             output int lat, output int kerr);
        int exp_k;
        kerr     = 0;
        lat      = -1;
        res      = '0;
        in_block = ct;
        in_valid = 1'b1;
        in_ready = (gap == 0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (noisy && c < 32) begin
                in_valid = 1'($urandom);
                in_block = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                lat = c;
                break;
            end
            exp_k = (c == 1) ? 32 : ((c <= 33) ? 33 - c : 0);
            if (int'(key_idx) != exp_k || !busy || out_ready) kerr++;
            if (glitch && c == 10) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end
        if (lat < 0) return;
        res = out_block;
        if (key_idx != 6'd0 || busy || out_ready) kerr++;
        repeat (gap) begin
            @(posedge clk); #1;
            if (!out_valid || out_block !== res || out_ready || busy) kerr++;
        end
        in_ready = 1'b1;
        @(posedge clk); #1;
        if (!out_ready || out_valid || busy || key_idx != 6'd32 || out_block !== '0) kerr++;
        in_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [31:0]  kseed;
        int           gap;
        bit           noisy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, res, pt;
        int lat, kerr, vcount;

        vecs[0] = '{pt: 128'h0, kseed: 32'h1, gap: 0, noisy: 1'b0};
        vecs[1] = '{pt: {128{1'b1}}, kseed: 32'h2, gap: 0, noisy: 1'b0};
        vecs[2] = '{pt: 128'h0123456789abcdef_fedcba9876543210, kseed: 32'h3, gap: 3, noisy: 1'b0};
        vecs[3] = '{pt: 128'h00000001_00000000_00000000_80000000, kseed: 32'h0, gap: 0, noisy: 1'b0};
        vecs[4] = '{pt: 128'hdeadbeef_cafef00d_12345678_9abcdef0, kseed: 32'h5, gap: 10, noisy: 1'b0};
        vecs[5] = '{pt: 128'h55555555_aaaaaaaa_33333333_cccccccc, kseed: 32'h6, gap: 1, noisy: 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_block = '0;
        fill_keys(32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 128'(out_ready), 128'd1);
        chk("reset_busy",  128'(busy),      128'd0);
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_kidx",  128'(key_idx),   128'd32);
        chk("reset_block", out_block,       128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            fill_keys(vecs[v].kseed);
            ct = encrypt(vecs[v].pt);
            run_block(ct, vecs[v].gap, vecs[v].noisy, 1'b0, res, lat, kerr);
            chk($sformatf("vec%0d_latency", v), 128'(lat), 128'd34);
            chk($sformatf("vec%0d_plain", v), res, vecs[v].pt);
            chk($sformatf("vec%0d_protocol", v), 128'(kerr), 128'd0);
        end

        // All-zero keys and ciphertext: the output must re-encrypt to zero.
        fill_keys(32'h0);
        run_block(128'h0, 0, 1'b0, 1'b0, res, lat, kerr);
        chk("zero_latency",  128'(lat),    128'd34);
        chk("zero_reencrypt", encrypt(res), 128'd0);
        chk("zero_protocol", 128'(kerr),   128'd0);

        // A reset glitch between edges must not disturb a running block.
        fill_keys(32'h77);
        pt = 128'h0f0f0f0f_f0f0f0f0_01234567_89abcdef;
        run_block(encrypt(pt), 2, 1'b0, 1'b1, res, lat, kerr);
        chk("glitch_latency", 128'(lat), 128'd34);
        chk("glitch_plain",   res,       pt);
        chk("glitch_protocol", 128'(kerr), 128'd0);

        // Reset for one edge while in round r=15 discards the block.
        fill_keys(32'h99);
        pt       = 128'h11112222_33334444_55556666_77778888;
        in_block = encrypt(pt);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !(busy && key_idx == 6'd15); c++) begin
            @(posedge clk); #1;
        end
        chk("midreset_reached_r15", 128'(key_idx), 128'd15);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_ready", 128'(out_ready), 128'd1);
        chk("midreset_busy",  128'(busy),      128'd0);
        chk("midreset_valid", 128'(out_valid), 128'd0);
        chk("midreset_kidx",  128'(key_idx),   128'd32);
        vcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) vcount++;
        end
        chk("midreset_no_output", 128'(vcount), 128'd0);
        pt = 128'h89abcdef_01234567_fedcba98_76543210;
        run_block(encrypt(pt), 0, 1'b0, 1'b0, res, lat, kerr);
        chk("postreset_plain",    res,        pt);
        chk("postreset_latency",  128'(lat),  128'd34);
        chk("postreset_protocol", 128'(kerr), 128'd0);

        // Random round trips.
        for (int n = 0; n < 1000; n++) begin
            fill_keys($urandom | 32'h1);
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_block(encrypt(pt), int'($urandom_range(0, 2)), 1'(n % 4 == 1), 1'b0, res, lat, kerr);
            chk($sformatf("rand%0d_plain", n), res, pt);
            chk($sformatf("rand%0d_latency", n), 128'(lat), 128'd34);
            chk($sformatf("rand%0d_protocol", n), 128'(kerr), 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
